// File: rtl/mux_reg_nx1_pkg.sv
// mux_reg_nx1_pkg
// Shared definitions for the registered N-to-1 multiplexer:
//   - MODE encodings (direct select / round-robin scan)
//   - FSM state encoding (IDLE: output empty, HOLD: output word pending)
//   - wrap_inc: circular increment used to advance the scan pointer
package mux_reg_nx1_pkg;

  localparam logic MUX_MODE_DIRECT = 1'b0;
  localparam logic MUX_MODE_SCAN   = 1'b1;

  typedef enum logic {
    MUX_ST_IDLE = 1'b0,
    MUX_ST_HOLD = 1'b1
  } mux_state_e;

  // (k + 1) mod n, for 0 <= k < n
  function automatic int wrap_inc(input int k, input int n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/mux_reg_nx1_rr_pick.sv
// mux_rr_pick
// Combinational circular first-one search over a channel mask.
// Ports:
//   MASK  in  CHANNELS  channel enables
//   PTR   in  SEL_W     channel where the search starts (must be < CHANNELS)
//   PICK  out SEL_W     first enabled channel at or after PTR, wrapping
//   FOUND out 1         at least one MASK bit is set
module mux_rr_pick #(
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] MASK,
  input  logic [SEL_W-1:0]    PTR,
  output logic [SEL_W-1:0]    PICK,
  output logic                FOUND
);

  // Offsets are walked from farthest to nearest, so the last hit written
  // is the one closest to PTR in circular order.
  always_comb begin : search
    int idx;
    PICK  = '0;
    FOUND = 1'b0;
    idx   = 0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = int'(PTR) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (MASK[idx]) begin
        PICK  = SEL_W'(idx);
        FOUND = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_reg_nx1.sv
// mux_reg_nx1
// Registered N-to-1 multiplexer with direct-select and round-robin scan
// modes. The selected word and its channel number are held in an output
// register until downstream accepts them.
// Ports:
//   CLK       in  1               clock, rising edge
//   RST       in  1               asynchronous active-low reset
//   I         in  WIDTH*CHANNELS  flattened inputs, channel k at I[k*WIDTH +: WIDTH]
//   S         in  SEL_W           channel select (direct mode)
//   MODE      in  1               0 = direct, 1 = scan
//   MASK      in  CHANNELS        channel enables (scan mode)
//   REQ       in  1               request a load
//   READY     in  1               downstream accepts Y this cycle
//   Y         out WIDTH           held output word
//   Y_SEL     out SEL_W           channel Y was taken from
//   VALID     out 1               Y/Y_SEL hold an unaccepted word
//   DBG_STATE out mux_state_e     current FSM state
//
// Handshake: a word is transferred on every rising edge with VALID=1 and
// READY=1. While VALID=1 and READY=0 the output is frozen. READY is ignored
// while VALID=0. A new word may be loaded on the same edge that the current
// one is accepted, so REQ=READY=1 streams one word per cycle.
module mux_reg_nx1
  import mux_reg_nx1_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [WIDTH*CHANNELS-1:0] I,
  input  logic [SEL_W-1:0]          S,
  input  logic                      MODE,
  input  logic [CHANNELS-1:0]       MASK,
  input  logic                      REQ,
  input  logic                      READY,
  output logic [WIDTH-1:0]          Y,
  output logic [SEL_W-1:0]          Y_SEL,
  output logic                      VALID,
  output mux_state_e                DBG_STATE
);

  mux_state_e         r_state;
  logic [WIDTH-1:0]   r_y;
  logic [SEL_W-1:0]   r_y_sel;
  logic [SEL_W-1:0]   r_ptr;

  logic [SEL_W-1:0]   w_pick;
  logic               w_found;
  logic [WIDTH-1:0]   w_direct_word;
  logic [WIDTH-1:0]   w_scan_word;
  logic               w_slot_free;
  logic               w_load;

  mux_rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_pick (
    .MASK  (MASK),
    .PTR   (r_ptr),
    .PICK  (w_pick),
    .FOUND (w_found)
  );

  // A select beyond the last channel loads zero rather than reading
  // outside the flattened input vector.
  always_comb begin
    w_direct_word = '0;
    if (int'(S) < CHANNELS) w_direct_word = I[int'(S)*WIDTH +: WIDTH];
  end

  assign w_scan_word = I[int'(w_pick)*WIDTH +: WIDTH];

  // The output register can take a new word when empty, or when the
  // current word leaves on this edge.
  assign w_slot_free = (r_state == MUX_ST_IDLE) || READY;
  // A scan with an empty mask has nothing to load.
  assign w_load      = REQ && w_slot_free && ((MODE == MUX_MODE_DIRECT) || w_found);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= MUX_ST_IDLE;
      r_y     <= '0;
      r_y_sel <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_state <= MUX_ST_HOLD;
      if (MODE == MUX_MODE_SCAN) begin
        r_y     <= w_scan_word;
        r_y_sel <= w_pick;
        r_ptr   <= SEL_W'(wrap_inc(int'(w_pick), CHANNELS));
      end else begin
        r_y     <= w_direct_word;
        r_y_sel <= S;
      end
    end else if ((r_state == MUX_ST_HOLD) && READY) begin
      r_state <= MUX_ST_IDLE;
    end
  end

  assign Y         = r_y;
  assign Y_SEL     = r_y_sel;
  assign VALID     = (r_state == MUX_ST_HOLD);
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_mux_reg_nx1.sv
module tb_mux_reg_nx1;
  import mux_reg_nx1_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- DUT signals ----------------
  logic [16*32-1:0] i16;
  logic [12*32-1:0] i12;
  logic [3:0]       s;
  logic             mode;
  logic [15:0]      mask;
  logic             req;
  logic             ready;

  logic [31:0]      y16, y12;
  logic [3:0]       ysel16, ysel12;
  logic             valid16, valid12;
  mux_state_e       st16, st12;

  mux_reg_nx1 #(.WIDTH(32), .CHANNELS(16)) dut16 (
    .CLK(CLK), .RST(RST), .I(i16), .S(s), .MODE(mode), .MASK(mask),
    .REQ(req), .READY(ready), .Y(y16), .Y_SEL(ysel16), .VALID(valid16),
    .DBG_STATE(st16)
  );

  mux_reg_nx1 #(.WIDTH(32), .CHANNELS(12)) dut12 (
    .CLK(CLK), .RST(RST), .I(i12), .S(s), .MODE(mode), .MASK(mask[11:0]),
    .REQ(req), .READY(ready), .Y(y12), .Y_SEL(ysel12), .VALID(valid12),
    .DBG_STATE(st12)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        mode;
    logic [3:0]  s;
    logic [15:0] mask;
    logic        req;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_y;
    logic [3:0]  exp_sel;
  } vec_t;

  localparam int NVEC = 24;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic m, input logic [3:0] sv, input logic [15:0] mk_mask,
                              input logic rq, input logic rd, input logic ev,
                              input logic [31:0] ey, input logic [3:0] es);
    vec_t v;
    v.mode = m; v.s = sv; v.mask = mk_mask; v.req = rq; v.ready = rd;
    v.exp_valid = ev; v.exp_y = ey; v.exp_sel = es;
    return v;
  endfunction

  localparam logic D = MUX_MODE_DIRECT;
  localparam logic C = MUX_MODE_SCAN;

  initial begin
    // streaming, direct mode, one word per cycle
    tbl[0]  = mk(D, 4'd0,  16'h0000, 1, 1, 1, 32'd0,  4'd0);
    tbl[1]  = mk(D, 4'd3,  16'h0000, 1, 1, 1, 32'd3,  4'd3);
    tbl[2]  = mk(D, 4'd4,  16'h0000, 1, 1, 1, 32'd4,  4'd4);
    tbl[3]  = mk(D, 4'd5,  16'h0000, 1, 1, 1, 32'd5,  4'd5);
    tbl[4]  = mk(D, 4'd7,  16'h0000, 1, 1, 1, 32'd7,  4'd7);
    tbl[5]  = mk(D, 4'd12, 16'h0000, 1, 1, 1, 32'd12, 4'd12);
    // accepted with no request -> empty; READY while empty is ignored
    tbl[6]  = mk(D, 4'd2,  16'h0000, 0, 1, 0, 32'd12, 4'd12);
    tbl[7]  = mk(D, 4'd2,  16'h0000, 0, 1, 0, 32'd12, 4'd12);
    // scan wrap over 16'h8421 starting at PTR=0
    tbl[8]  = mk(C, 4'd9,  16'h8421, 1, 1, 1, 32'd0,  4'd0);
    tbl[9]  = mk(C, 4'd9,  16'h8421, 1, 1, 1, 32'd5,  4'd5);
    tbl[10] = mk(C, 4'd9,  16'h8421, 1, 1, 1, 32'd10, 4'd10);
    tbl[11] = mk(C, 4'd9,  16'h8421, 1, 1, 1, 32'd15, 4'd15);
    tbl[12] = mk(C, 4'd9,  16'h8421, 1, 1, 1, 32'd0,  4'd0);
    // backpressure in scan mode: frozen, PTR stays at 1
    tbl[13] = mk(C, 4'd9,  16'h8421, 1, 0, 1, 32'd0,  4'd0);
    // empty mask: current word accepted, nothing loaded; idle stays idle
    tbl[14] = mk(C, 4'd9,  16'h0000, 1, 1, 0, 32'd0,  4'd0);
    tbl[15] = mk(C, 4'd9,  16'h0000, 1, 1, 0, 32'd0,  4'd0);
    // PTR=1 with mask 3: pick 1, then wrap to 0
    tbl[16] = mk(C, 4'd9,  16'h0003, 1, 1, 1, 32'd1,  4'd1);
    tbl[17] = mk(C, 4'd9,  16'h0003, 1, 1, 1, 32'd0,  4'd0);
    // direct load leaves PTR at 1
    tbl[18] = mk(D, 4'd7,  16'h0003, 1, 1, 1, 32'd7,  4'd7);
    tbl[19] = mk(C, 4'd7,  16'h0003, 1, 1, 1, 32'd1,  4'd1);
    // last channel in both modes; pick 15 wraps PTR to 0
    tbl[20] = mk(D, 4'd15, 16'h0000, 1, 1, 1, 32'd15, 4'd15);
    tbl[21] = mk(C, 4'd0,  16'h8000, 1, 1, 1, 32'd15, 4'd15);
    tbl[22] = mk(C, 4'd0,  16'h8001, 1, 1, 1, 32'd0,  4'd0);
    tbl[23] = mk(D, 4'd0,  16'h0000, 0, 1, 0, 32'd0,  4'd0);
  end

  // ---------------- test ----------------
  initial begin
    i16 = '0; i12 = '0;
    s = 4'd9; mode = MUX_MODE_DIRECT; mask = '0; req = 1'b1; ready = 1'b0;

    // reset held with REQ=1
    repeat (2) step();
    check("rst_y",     y16,     32'd0);
    check("rst_sel",   {28'd0, ysel16}, 32'd0);
    check("rst_valid", {31'd0, valid16}, 32'd0);
    check("rst_valid12", {31'd0, valid12}, 32'd0);

    for (int k = 0; k < 16; k++) i16[k*32 +: 32] = 32'(k);
    for (int k = 0; k < 12; k++) i12[k*32 +: 32] = 32'h100 + 32'(k);
    RST = 1'b1;

    // direct load S=9
    step();
    req = 1'b0;
    check("ld9_y",     y16,     32'd9);
    check("ld9_sel",   {28'd0, ysel16}, 32'd9);
    check("ld9_valid", {31'd0, valid16}, 32'd1);
    s = 4'd3;
    step();
    check("ld9_hold_y", y16, 32'd9);

    // backpressure: inputs and controls change, output frozen
    i16[9*32 +: 32] = 32'd99;
    for (int c = 0; c < 5; c++) begin
      req  = c[0];
      mode = c[1];
      mask = 16'hFFFF;
      s    = 4'(c);
      step();
      check("bp_y",     y16,     32'd9);
      check("bp_sel",   {28'd0, ysel16}, 32'd9);
      check("bp_valid", {31'd0, valid16}, 32'd1);
    end
    req = 1'b0; mode = MUX_MODE_DIRECT; mask = '0; ready = 1'b1;
    step();
    check("bp_release_valid", {31'd0, valid16}, 32'd0);
    i16[9*32 +: 32] = 32'd9;

    // table-driven streaming / scan
    for (int v = 0; v < NVEC; v++) begin
      mode  = tbl[v].mode;
      s     = tbl[v].s;
      mask  = tbl[v].mask;
      req   = tbl[v].req;
      ready = tbl[v].ready;
      step();
      check($sformatf("vec%0d_valid", v), {31'd0, valid16}, {31'd0, tbl[v].exp_valid});
      check($sformatf("vec%0d_y", v),     y16,              tbl[v].exp_y);
      check($sformatf("vec%0d_sel", v),   {28'd0, ysel16},  {28'd0, tbl[v].exp_sel});
    end

    // CHANNELS=12: out-of-range select loads zero but still completes
    mode = MUX_MODE_DIRECT; mask = '0; req = 1'b1; ready = 1'b1; s = 4'd13;
    step();
    check("oor12_y",     y12,     32'd0);
    check("oor12_sel",   {28'd0, ysel12}, 32'd13);
    check("oor12_valid", {31'd0, valid12}, 32'd1);
    check("oor16_y",     y16,     32'd13);
    s = 4'd11;
    step();
    check("last12_y",   y12, 32'h10B);
    check("last12_sel", {28'd0, ysel12}, 32'd11);
    s = 4'd13;
    step();
    check("oor12b_sel", {28'd0, ysel12}, 32'd13);
    req = 1'b0; ready = 1'b0;
    step();
    check("hold12_valid", {31'd0, valid12}, 32'd1);

    // asynchronous reset mid-HOLD, between clock edges
    #2 RST = 1'b0;
    #1;
    check("arst12_y",     y12,     32'd0);
    check("arst12_valid", {31'd0, valid12}, 32'd0);
    check("arst12_sel",   {28'd0, ysel12}, 32'd0);
    check("arst16_valid", {31'd0, valid16}, 32'd0);
    #2 RST = 1'b1;

    // first scan after reset starts at channel 0
    mode = MUX_MODE_SCAN; mask = 16'hFFFF; req = 1'b1; ready = 1'b1;
    step();
    check("scan0_12_sel", {28'd0, ysel12}, 32'd0);
    check("scan0_12_y",   y12,     32'h100);
    check("scan0_16_sel", {28'd0, ysel16}, 32'd0);
    step();
    check("scan1_12_sel", {28'd0, ysel12}, 32'd1);
    check("scan1_12_y",   y12,     32'h101);
    req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
